pipe_stage_skid: RTL and testbench

- Parametrised next-generation pipeline stage register for the five-stage CPU, e.g. MEM/WB or any inter-stage boundary.
- Replaces the plain enable/flush register with a 2-entry skid buffer and a valid/ready handshake, so a stage boundary holds in-flight data when downstream stalls.
- Keeps flush and the exception-request bubble insertion (exception-entry PC with NOP).
- Adds a saturating stall counter for performance monitoring.

---
 rtl/pipe_stage_skid.sv | 173 +++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid : valid/ready pipeline stage register with 2-entry skid,
//                   flush, exception-bubble insertion and a saturating stall counter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid #(
  parameter int          DATA_W    = 128,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] PC_EXC    = 32'h0000_4180,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_req,
  input  logic              i_cnt_clr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_instr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_bubble,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                bubble_q, bubble_d;
  logic [31:0]         skid_pc_q, skid_pc_d;
  logic [31:0]         skid_instr_q, skid_instr_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic in_fire;
  logic out_fire;
  logic valid;

  assign valid    = (state_q != ST_EMPTY);
  assign in_fire  = i_valid & ready_q;
  assign out_fire = valid & i_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    data_d       = data_q;
    bubble_d     = bubble_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_data_d  = skid_data_q;

    if (i_req) begin
      // Exception entry replaces everything in flight with a single bubble
      state_d      = ST_ONE;
      pc_d         = PC_EXC;
      instr_d      = INSTR_NOP;
      data_d       = '0;
      bubble_d     = 1'b1;
      skid_pc_d    = '0;
      skid_instr_d = '0;
      skid_data_d  = '0;
    end else if (i_flush) begin
      state_d  = ST_EMPTY;
      pc_d     = PC_RESET;
      instr_d  = INSTR_NOP;
      data_d   = '0;
      bubble_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d  = ST_ONE;
            pc_d     = i_pc;
            instr_d  = i_instr;
            data_d   = i_data;
            bubble_d = 1'b0;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            pc_d     = i_pc;
            instr_d  = i_instr;
            data_d   = i_data;
            bubble_d = 1'b0;
          end else if (in_fire) begin
            state_d      = ST_FULL;
            skid_pc_d    = i_pc;
            skid_instr_d = i_instr;
            skid_data_d  = i_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d  = ST_ONE;
            pc_d     = skid_pc_q;
            instr_d  = skid_instr_q;
            data_d   = skid_data_q;
            bubble_d = 1'b0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Ready is a flop so downstream i_ready never reaches o_ready combinationally
  assign ready_d = (state_d != ST_FULL);

  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (valid && !i_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_EMPTY;
      ready_q      <= 1'b1;
      pc_q         <= PC_RESET;
      instr_q      <= INSTR_NOP;
      data_q       <= '0;
      bubble_q     <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      data_q       <= data_d;
      bubble_q     <= bubble_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_data_q  <= skid_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid;
  assign o_pc        = pc_q;
  assign o_instr     = instr_q;
  assign o_data      = data_q;
  assign o_bubble    = bubble_q;
  assign o_stall_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid : directed-vector bench for pipe_stage_skid
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush, req, cnt_clr;
  logic              in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [31:0]       in_pc, in_instr, out_pc, out_instr;
  logic [DATA_W-1:0] in_data, out_data;
  logic              out_bubble;
  logic [CNT_W-1:0]  stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_skid #(
    .DATA_W   (DATA_W),
    .PC_RESET (32'h0000_3000),
    .PC_EXC   (32'h0000_4180),
    .INSTR_NOP(32'h0000_0000),
    .CNT_W    (CNT_W)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_flush    (flush),
    .i_req      (req),
    .i_cnt_clr  (cnt_clr),
    .i_valid    (in_valid),
    .o_ready    (in_ready),
    .i_pc       (in_pc),
    .i_instr    (in_instr),
    .i_data     (in_data),
    .o_valid    (out_valid),
    .i_ready    (out_ready),
    .o_pc       (out_pc),
    .o_instr    (out_instr),
    .o_data     (out_data),
    .o_bubble   (out_bubble),
    .o_stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Payload is derived from pc so every entry is distinguishable
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input logic [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr_of(pc);
    in_data  = data_of(pc);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".pc"},    64'(out_pc), 64'(pc));
    chk({tag, ".instr"}, 64'(out_instr), 64'(instr_of(pc)));
    chk({tag, ".data"},  64'(out_data), 64'(data_of(pc)));
    chk({tag, ".bub"},   64'(out_bubble), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".pc"},    64'(out_pc), 64'h3000);
    chk({tag, ".instr"}, 64'(out_instr), 64'd0);
    chk({tag, ".data"},  64'(out_data), 64'd0);
    chk({tag, ".bub"},   64'(out_bubble), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req = 1'b0; cnt_clr = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0);
    tick(); tick();
    chk_reset_vals("rst");
    chk("rst.cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // Streaming with downstream always ready
    drive(1'b1, 32'h3000); tick();
    chk_entry("s0", 32'h3000); chk("s0.rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h3004); tick();
    chk_entry("s1", 32'h3004); chk("s1.rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h3008); tick();
    chk_entry("s2", 32'h3008); chk("s2.rdy", 64'(in_ready), 64'd1);
    drive(1'b0, 32'h0); tick();
    chk("s3.valid", 64'(out_valid), 64'd0);
    chk("s3.cnt", 64'(stall_cnt), 64'd0);

    // Backpressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 32'h3000); tick();
    chk_entry("b0", 32'h3000); chk("b0.rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h3004); tick();
    chk_entry("b1", 32'h3000); chk("b1.rdy", 64'(in_ready), 64'd0);
    chk("b1.cnt", 64'(stall_cnt), 64'd1);
    drive(1'b0, 32'h0); tick();
    chk("b2.cnt", 64'(stall_cnt), 64'd2);
    chk("b2.rdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1; tick();
    chk_entry("b3", 32'h3004); chk("b3.rdy", 64'(in_ready), 64'd1);
    chk("b3.cnt", 64'(stall_cnt), 64'd2);
    tick();
    chk("b4.valid", 64'(out_valid), 64'd0);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("b5.cnt", 64'(stall_cnt), 64'd0);

    // Flush while FULL, with a valid input presented that cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h3100); tick();
    drive(1'b1, 32'h3104); tick();
    chk("f0.rdy", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h3108); flush = 1'b1; tick();
    flush = 1'b0; drive(1'b0, 32'h0);
    chk_reset_vals("f1");
    out_ready = 1'b1; tick(); tick();
    chk("f2.valid", 64'(out_valid), 64'd0);

    // Flush in ONE drops the input offered that cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h3200); tick();
    drive(1'b1, 32'h3204); flush = 1'b1; tick();
    flush = 1'b0; drive(1'b0, 32'h0);
    chk_reset_vals("f3");

    // Request together with flush in ONE inserts a bubble
    drive(1'b1, 32'h3010); tick();
    chk_entry("r0", 32'h3010);
    drive(1'b1, 32'h3014); req = 1'b1; flush = 1'b1; tick();
    req = 1'b0; flush = 1'b0; drive(1'b0, 32'h0);
    chk("r1.valid", 64'(out_valid), 64'd1);
    chk("r1.bub",   64'(out_bubble), 64'd1);
    chk("r1.pc",    64'(out_pc), 64'h4180);
    chk("r1.instr", 64'(out_instr), 64'd0);
    chk("r1.data",  64'(out_data), 64'd0);
    chk("r1.rdy",   64'(in_ready), 64'd1);
    tick();
    chk("r2.bub", 64'(out_bubble), 64'd1);
    chk("r2.pc",  64'(out_pc), 64'h4180);
    out_ready = 1'b1; tick();
    chk("r3.valid", 64'(out_valid), 64'd0);

    // Counter saturates and clears
    cnt_clr = 1'b1; out_ready = 1'b0;
    drive(1'b1, 32'h3020); tick();
    cnt_clr = 1'b0; drive(1'b0, 32'h0);
    chk("c0.cnt", 64'(stall_cnt), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("c1.cnt", 64'(stall_cnt), 64'd15);
    chk_entry("c1", 32'h3020);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("c2.cnt", 64'(stall_cnt), 64'd0);
    tick();
    chk("c3.cnt", 64'(stall_cnt), 64'd1);

    // Async reset mid-cycle while FULL
    drive(1'b1, 32'h3034); tick();
    drive(1'b0, 32'h0);
    chk("a0.rdy", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1 chk_reset_vals("a1");
    chk("a1.cnt", 64'(stall_cnt), 64'd0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'h3040); tick();
    drive(1'b0, 32'h0);
    chk_entry("a2", 32'h3040);
    tick();
    chk("a3.valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
